// File: rtl/operand_read_stage.sv
// -----------------------------------------------------------------------------
// operand_read_stage
//
// Decode-side consumer of the write-back stage for an LC-3b pipeline.
//   * Holds the 8x16 register file and the NZP condition-code register, both
//     written from write-back.
//   * Reads SR1/SR2 (and NZP) with same-cycle write-back bypass.
//   * Keeps a per-register in-flight counter plus one for the CC register and
//     stalls decode on RAW hazards or when a counter would overflow.
//   * Issues operands to execute through a one-entry valid/ready register.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wb_ld_reg       write-back register write enable
//   wb_dest_reg     write-back destination register
//   wb_reg_data     write-back data
//   wb_ld_cc        write-back CC load enable
//   wb_gencc        write-back generated NZP
//   id_valid        decode presents an instruction
//   id_sr1          source register 1 (always read)
//   id_sr2          source register 2
//   id_reads_sr2    instruction uses SR2
//   id_reads_cc     instruction uses NZP (BR)
//   id_dr           destination register
//   id_writes_reg   instruction will write DR at write-back
//   id_writes_cc    instruction will load CC at write-back
//   id_stall        decode must hold its instruction this cycle (combinational)
//   ex_ready        execute accepts ex_* this cycle
//   ex_valid        ex_* payload valid
//   ex_sr1_data     SR1 operand
//   ex_sr2_data     SR2 operand (0 when the instruction does not read SR2)
//   ex_nzp          NZP value for branch resolution
//   ex_dr           destination register, passed through
//   sb_err          sticky: write-back retired a register/CC with no pending write
// -----------------------------------------------------------------------------
module operand_read_stage #(
  parameter int         CNT_W   = 2,
  parameter logic [2:0] NZP_RST = 3'b010
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        wb_ld_reg,
  input  logic [2:0]  wb_dest_reg,
  input  logic [15:0] wb_reg_data,
  input  logic        wb_ld_cc,
  input  logic [2:0]  wb_gencc,

  input  logic        id_valid,
  input  logic [2:0]  id_sr1,
  input  logic [2:0]  id_sr2,
  input  logic        id_reads_sr2,
  input  logic        id_reads_cc,
  input  logic [2:0]  id_dr,
  input  logic        id_writes_reg,
  input  logic        id_writes_cc,
  output logic        id_stall,

  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [15:0] ex_sr1_data,
  output logic [15:0] ex_sr2_data,
  output logic [2:0]  ex_nzp,
  output logic [2:0]  ex_dr,

  output logic        sb_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Payload handed to execute; one struct keeps the issue path a single copy.
  typedef struct packed {
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [2:0]  nzp;
    logic [2:0]  dr;
  } ex_payload_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]      regs [8];
  logic [2:0]       nzp;
  logic [CNT_W-1:0] pend [8];
  logic [CNT_W-1:0] pend_cc;

  ex_payload_t      ex_q;
  logic             ex_valid_q;
  logic             sb_err_q;

  // ---------------------------------------------------------------------------
  // Operand read with write-back bypass
  // ---------------------------------------------------------------------------
  logic        wb_hits_sr1;
  logic        wb_hits_sr2;
  ex_payload_t operands;

  // NOTE: every variable written in an always_comb gets a default on entry, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wb_hits_sr1 = wb_ld_reg && (wb_dest_reg == id_sr1);
    wb_hits_sr2 = wb_ld_reg && (wb_dest_reg == id_sr2);

    operands     = '0;
    operands.sr1 = wb_hits_sr1 ? wb_reg_data : regs[id_sr1];
    if (id_reads_sr2) begin
      operands.sr2 = wb_hits_sr2 ? wb_reg_data : regs[id_sr2];
    end
    operands.nzp = wb_ld_cc ? wb_gencc : nzp;
    operands.dr  = id_dr;
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // A source is busy when some older writer will still be outstanding after
  // this cycle: two or more in flight, or exactly one that is not retiring now
  // (a retiring one is covered by the bypass).
  function automatic logic src_busy(input logic [CNT_W-1:0] cnt,
                                    input logic             retiring);
    return (cnt > CNT_ONE) || ((cnt == CNT_ONE) && !retiring);
  endfunction

  logic haz_sr1;
  logic haz_sr2;
  logic haz_cc;
  logic full_reg;
  logic full_cc;
  logic hazard;
  logic accept;
  logic issue;

  always_comb begin
    haz_sr1  = src_busy(pend[id_sr1], wb_hits_sr1);
    haz_sr2  = id_reads_sr2 && src_busy(pend[id_sr2], wb_hits_sr2);
    haz_cc   = id_reads_cc  && src_busy(pend_cc, wb_ld_cc);
    // A full counter blocks a new writer even if a retire happens this cycle;
    // this keeps the counters from ever wrapping.
    full_reg = id_writes_reg && (pend[id_dr] == CNT_MAX);
    full_cc  = id_writes_cc  && (pend_cc == CNT_MAX);
    hazard   = haz_sr1 || haz_sr2 || haz_cc || full_reg || full_cc;
  end

  assign accept   = !ex_valid_q || ex_ready;
  assign issue    = id_valid && accept && !hazard;
  assign id_stall = id_valid && !issue;

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0] inc_mask;
  logic [7:0] dec_mask;
  logic       wb_underflow;

  assign inc_mask = (issue && id_writes_reg) ? (8'b1 << id_dr)       : 8'b0;
  assign dec_mask = wb_ld_reg                ? (8'b1 << wb_dest_reg) : 8'b0;

  // A retire against an empty counter is a protocol error from write-back;
  // the write itself is still honoured.
  assign wb_underflow = (wb_ld_reg && (pend[wb_dest_reg] == CNT_ZERO)) ||
                        (wb_ld_cc  && (pend_cc == CNT_ZERO));

  // Simultaneous issue and retire on the same counter cancel out; a decrement
  // never goes below zero.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + CNT_ONE;
    end else if (dec && !inc && (cnt != CNT_ZERO)) begin
      nxt = cnt - CNT_ONE;
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is only eight flops wide per bit, not a RAM
      // macro, so clearing it in reset costs nothing and gives defined reads.
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      nzp        <= NZP_RST;
      pend_cc    <= '0;
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      sb_err_q   <= 1'b0;
    end else begin
      if (wb_ld_reg) begin
        regs[wb_dest_reg] <= wb_reg_data;
      end
      if (wb_ld_cc) begin
        nzp <= wb_gencc;
      end

      for (int i = 0; i < 8; i++) begin
        pend[i] <= cnt_next(pend[i], inc_mask[i], dec_mask[i]);
      end
      pend_cc <= cnt_next(pend_cc, issue && id_writes_cc, wb_ld_cc);

      // One-entry pipeline register: load on issue, drain when execute takes
      // the held entry, otherwise hold.
      if (issue) begin
        ex_q       <= operands;
        ex_valid_q <= 1'b1;
      end else if (ex_ready) begin
        ex_valid_q <= 1'b0;
      end

      if (wb_underflow) begin
        sb_err_q <= 1'b1;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_sr1_data = ex_q.sr1;
  assign ex_sr2_data = ex_q.sr2;
  assign ex_nzp      = ex_q.nzp;
  assign ex_dr       = ex_q.dr;
  assign sb_err      = sb_err_q;

endmodule
